// File: rtl/emul_bf16_pack.sv
// emul_bf16_pack: rounds 4 fp32 lanes to bf16, packs them and buffers the words in a ready/valid FIFO
module emul_bf16_pack #(
  parameter int DEPTH = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stage_start,
  input  logic               in_tvalid,
  input  logic [127:0]       in_tdata,
  output logic               out_tvalid,
  input  logic               out_tready,
  output logic [63:0]        out_tdata,
  output logic               overflow,
  output logic [COUNT_W-1:0] accepted_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  logic          start_q, clr, pipe_valid, push, pop, drop;
  logic [63:0]   pipe_data, rounded;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  function automatic logic [15:0] rnd(input logic [31:0] x);
    logic [31:0] sum;
    sum = x + 32'h0000_7fff + {31'b0, x[16]};
    return (&x[30:23] && |x[22:0]) ? {x[31], 8'hff, 7'h40} : sum[31:16];
  endfunction
  always_comb begin
    rounded = '0;
    for (int i = 0; i < 4; i++) rounded[16*i +: 16] = rnd(in_tdata[32*i +: 32]);
  end
  assign clr        = !rst_n || (stage_start && !start_q);
  assign out_tvalid = count != '0;
  assign out_tdata  = mem[rd_ptr];
  assign pop        = out_tvalid && out_tready;
  assign push       = pipe_valid && (count != FULL || pop);
  assign drop       = pipe_valid && !push;
  always_ff @(posedge clk) begin
    start_q <= stage_start;
    if (clr) begin
      pipe_valid   <= 1'b0;
      pipe_data    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      accepted_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      pipe_valid <= stage_start && in_tvalid;
      pipe_data  <= rounded;
      if (push) begin
        mem[wr_ptr]  <= pipe_data;
        wr_ptr       <= wr_ptr + 1'b1;
        accepted_cnt <= accepted_cnt + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop) overflow <= 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_emul_bf16_pack.sv
// tb_emul_bf16_pack: directed vectors with hand-computed bf16 words, FIFO fill/drain and clear checks
module tb_emul_bf16_pack;
  logic         clk = 1'b0;
  logic         rst_n, stage_start, in_tvalid, out_tready;
  logic [127:0] in_tdata;
  logic         out_tvalid, overflow;
  logic [63:0]  out_tdata;
  logic [15:0]  accepted_cnt;
  logic         w_tvalid, w_overflow;
  logic [63:0]  w_tdata;
  logic [3:0]   w_cnt;
  int           n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  emul_bf16_pack #(.DEPTH(4), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stage_start(stage_start), .in_tvalid(in_tvalid),
    .in_tdata(in_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .out_tdata(out_tdata), .overflow(overflow), .accepted_cnt(accepted_cnt)
  );

  emul_bf16_pack #(.DEPTH(4), .COUNT_W(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stage_start(stage_start), .in_tvalid(in_tvalid),
    .in_tdata(in_tdata), .out_tvalid(w_tvalid), .out_tready(1'b1),
    .out_tdata(w_tdata), .overflow(w_overflow), .accepted_cnt(w_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // lanes with zero low halves round exactly, so the expected word is just the upper halves
  function automatic logic [127:0] din(input int k);
    logic [127:0] d;
    for (int i = 0; i < 4; i++) d[32*i +: 32] = {16'h1000 + 16'(k*16 + i), 16'h0000};
    return d;
  endfunction

  function automatic logic [63:0] exp_w(input int k);
    logic [63:0] e;
    for (int i = 0; i < 4; i++) e[16*i +: 16] = 16'h1000 + 16'(k*16 + i);
    return e;
  endfunction

  task automatic pulse_start;
    stage_start = 1'b0;
    step;
    stage_start = 1'b1;
    step;
  endtask

  initial begin
    rst_n = 1'b0; stage_start = 1'b0; in_tvalid = 1'b0; out_tready = 1'b0; in_tdata = '0;
    step; step;
    chk("rst_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_tdata", out_tdata, 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_cnt", 64'(accepted_cnt), 64'd0);
    rst_n = 1'b1;
    stage_start = 1'b1;
    step;

    in_tvalid = 1'b1;
    in_tdata = {32'h7F800001, 32'h3F808001, 32'h3F818000, 32'h3F808000};
    step;
    in_tvalid = 1'b0;
    chk("lat_not_yet", 64'(out_tvalid), 64'd0);
    step;
    chk("rnd_tvalid", 64'(out_tvalid), 64'd1);
    chk("rnd_data", out_tdata, 64'h7FC0_3F81_3F82_3F80);
    chk("rnd_cnt", 64'(accepted_cnt), 64'd1);
    out_tready = 1'b1;
    step;
    out_tready = 1'b0;
    chk("rnd_popped", 64'(out_tvalid), 64'd0);

    in_tvalid = 1'b1;
    in_tdata = {32'h00008000, 32'h80000000, 32'hFF800000, 32'h7F7FFFFF};
    step;
    in_tvalid = 1'b0;
    step;
    chk("inf_data", out_tdata, 64'h0000_8000_FF80_7F80);
    chk("inf_cnt", 64'(accepted_cnt), 64'd2);
    out_tready = 1'b1;
    step;
    out_tready = 1'b0;

    stage_start = 1'b0;
    in_tvalid = 1'b1;
    in_tdata = din(7);
    step; step; step;
    in_tvalid = 1'b0;
    chk("gate_tvalid", 64'(out_tvalid), 64'd0);
    chk("gate_cnt", 64'(accepted_cnt), 64'd2);
    stage_start = 1'b1;
    step;
    chk("clr_cnt", 64'(accepted_cnt), 64'd0);

    for (int k = 1; k <= 6; k++) begin
      in_tvalid = 1'b1;
      in_tdata = din(k);
      step;
      if (k == 5) chk("fill_ovf_before", 64'(overflow), 64'd0);
      if (k == 6) chk("fill_ovf_after5", 64'(overflow), 64'd1);
    end
    in_tvalid = 1'b0;
    step;
    chk("fill_cnt", 64'(accepted_cnt), 64'd4);
    chk("fill_ovf", 64'(overflow), 64'd1);
    chk("fill_head", out_tdata, exp_w(1));
    out_tready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_tvalid", 64'(out_tvalid), 64'd1);
      chk("drain_data", out_tdata, exp_w(k));
      step;
    end
    chk("drain_empty", 64'(out_tvalid), 64'd0);
    out_tready = 1'b0;

    pulse_start;
    chk("clr2_ovf", 64'(overflow), 64'd0);
    for (int k = 11; k <= 20; k++) begin
      in_tvalid = 1'b1;
      in_tdata = din(k);
      out_tready = k >= 16;
      if (k >= 16) chk("full_pop_head", out_tdata, exp_w(k - 5));
      step;
    end
    in_tvalid = 1'b0;
    for (int k = 16; k <= 20; k++) begin
      chk("full_drain_head", out_tdata, exp_w(k));
      step;
    end
    chk("full_empty", 64'(out_tvalid), 64'd0);
    chk("full_ovf", 64'(overflow), 64'd0);
    chk("full_cnt", 64'(accepted_cnt), 64'd10);
    out_tready = 1'b0;

    for (int k = 31; k <= 33; k++) begin
      in_tvalid = 1'b1;
      in_tdata = din(k);
      step;
    end
    in_tvalid = 1'b0;
    step; step;
    chk("buf3_cnt", 64'(accepted_cnt), 64'd13);
    chk("hold_head", out_tdata, exp_w(31));
    stage_start = 1'b0;
    step;
    chk("hold_head2", out_tdata, exp_w(31));
    stage_start = 1'b1;
    step;
    chk("start_tvalid", 64'(out_tvalid), 64'd0);
    chk("start_cnt", 64'(accepted_cnt), 64'd0);
    chk("start_ovf", 64'(overflow), 64'd0);

    in_tvalid = 1'b1;
    in_tdata = din(40);
    step;
    in_tvalid = 1'b0;
    rst_n = 1'b0;
    step;
    chk("mid_rst_tvalid", 64'(out_tvalid), 64'd0);
    chk("mid_rst_tdata", out_tdata, 64'd0);
    rst_n = 1'b1;
    step;
    chk("mid_rst_lost", 64'(out_tvalid), 64'd0);
    chk("mid_rst_cnt", 64'(accepted_cnt), 64'd0);

    out_tready = 1'b1;
    for (int k = 50; k < 67; k++) begin
      in_tvalid = 1'b1;
      in_tdata = din(k);
      step;
    end
    in_tvalid = 1'b0;
    step; step;
    chk("wrap_cnt", 64'(w_cnt), 64'd1);
    chk("wrap_main_cnt", 64'(accepted_cnt), 64'd17);
    chk("wrap_ovf", 64'(w_overflow), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/emul_bf16_pack.md
# emul_bf16_pack

Result-side neighbour of the elementwise multiply stage. It consumes the 4-lane fp32 result word, rounds each lane to bfloat16 (round-to-nearest-even) and packs the lanes into one 64-bit word. The packed words are buffered in a small FIFO and handed to the next stage over a ready/valid handshake. The multiply stage has no backpressure, so this block absorbs bursts, drops and flags writes when the buffer overflows, and counts accepted words per stage.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16.
- COUNT_W, 16, width of the accepted-word counter.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- stage_start  in  1  stage-active level, same signal fed to the multiply stage. Its rising edge clears this block.
- in_tvalid  in  1  result valid from the multiply stage. No ready is returned.
- in_tdata  in  128  4 fp32 lanes; lane i = bits [32i+31:32i].
- out_tvalid  out  1  FIFO head valid.
- out_tready  in  1  downstream accepts the head.
- out_tdata  out  64  4 bf16 lanes; lane i = bits [16i+15:16i], taken from fp32 lane i.
- overflow  out  1  sticky: at least one word was dropped because the FIFO was full.
- accepted_cnt  out  COUNT_W  words written into the FIFO since the last clear.

## Operation
- **Clear.**
  - A clear happens when rst_n is low at a clock edge, or when stage_start is high with its registered copy low (start pulse).
  - Clear empties the FIFO and zeroes all storage, the pipe register, overflow and accepted_cnt.
  - Clear has priority over every other event in the same cycle. An input presented on the start-pulse cycle is discarded.
- **Input gating.** in_tvalid is honoured only while stage_start is high. While stage_start is low, the FIFO keeps draining and the counters hold.
- **Rounding (per lane, combinational, ahead of the pipe register).** Let x be the 32-bit lane value.
  - If x[30:23] = 0xFF and x[22:0] ≠ 0 (NaN): result = {x[31], 8'hFF, 7'h40} (quiet NaN, sign kept).
  - Otherwise: result = (x + 0x7FFF + x[16])[31:16]. The sum is computed modulo 2^32.
  - Infinity passes through unchanged. Finite overflow rounds to infinity naturally, e.g. 0x7F7FFFFF → 0x7F80.
  - Denormals are rounded with the same rule; no flush to zero.
- **Pipe register.** One stage holding pipe_valid and pipe_data[63:0]. It loads the gated in_tvalid and the rounded word every cycle.
- **FIFO write.**
  - pipe_valid is written into the FIFO when count < DEPTH, or when count = DEPTH and a pop happens in the same cycle.
  - Otherwise the word is dropped and overflow is set to 1.
- **Pop.** A pop occurs when out_tvalid and out_tready are both high. The head advances and the read pointer wraps modulo DEPTH.
- **Simultaneous push and pop.** Count is unchanged; this holds when full and when at count 1. A push into an empty FIFO does not bypass the FIFO; the word appears at the head the next cycle.
- **accepted_cnt.**
  - Increments by 1 on each accepted FIFO write.
  - Wraps from 2^COUNT_W−1 to 0.
  - Dropped words are not counted.
- **Head stability.** While out_tvalid is high and out_tready is low, out_tdata must not change.

## Timing
- **Reset values.** out_tvalid = 0, out_tdata = 0, overflow = 0, accepted_cnt = 0.
- **Latency.** in_tvalid high at edge N (stage active, FIFO empty) → pipe_valid after N → out_tvalid high and out_tdata valid after edge N+1.
- **Throughput.** One word per cycle in and out while out_tready is held high; no bubbles.
- **Output timing.** out_tvalid and out_tdata come directly from registers (FIFO storage and count); no combinational path from in_tdata.
- **accepted_cnt and overflow** update at the same edge as the FIFO write decision.
- **Reset mid-stream.** Outputs are at reset values one edge after rst_n is sampled low. A pending pipe word is lost.
- **Start pulse while data is buffered.** The same clear takes effect at the next edge; out_tvalid is 0 after that edge.

## Test plan
- **Rounding.** Lanes 0..3 = 0x3F808000, 0x3F818000, 0x3F808001, 0x7F800001 → out_tdata = 0x7FC0_3F81_3F82_3F80 two edges later; accepted_cnt = 1.
- **Overflow rounding, infinity and sign.** Lanes = 0x7F7FFFFF, 0xFF800000, 0x80000000, 0x00008000 → lanes 0x7F80, 0xFF80, 0x8000, 0x0000.
- **Fill and overflow.**
  - Setup: DEPTH = 4, out_tready = 0, 6 consecutive valid words.
  - Required: the first 4 words are held; accepted_cnt = 4; overflow = 1 after the 5th word; head = word 1.
  - Then raise out_tready: the 4 words drain in order and out_tvalid falls.
- **Full with simultaneous pop.** FIFO full, out_tready = 1 and a new word arriving every cycle → no drops; overflow stays 0; count stays 4; output order is preserved.
- **Clear.**
  - Start pulse with 3 words buffered → out_tvalid = 0, accepted_cnt = 0 and overflow = 0 the next cycle.
  - in_tvalid while stage_start is low → no write.
- **Counter wrap.** COUNT_W = 4, 17 accepted words → accepted_cnt = 1.
